// File: rtl/i2c_write_master_pkg.sv
// Shared definitions for the I2C single-byte write master: FSM states,
// quarter-phase names and the R/W bit value used for a write.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK1,
        DATA,
        ACK2,
        STOP,
        DONE
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic W_BIT = 1'b0;

endpackage

// File: rtl/i2c_write_master_if.sv
// Request/status and open-drain line signals of the I2C write master.
interface i2c_write_master_if;

    logic       start;
    logic [6:0] addr;
    logic [7:0] data;
    logic       sda_in;
    logic       scl_o;
    logic       sda_o;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        input  start, addr, data, sda_in,
        output scl_o, sda_o, busy, done, ack_err
    );

    modport slave (
        input  scl_o, sda_o, busy, done, ack_err,
        output start, addr, data, sda_in
    );

endinterface

// File: rtl/i2c_write_master_quarter_tick.sv
// Quarter-bit-period divider: one tick every CLK_DIV clocks while enabled,
// plus the 2-bit phase of the current quarter within a bit slot.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       tick,
    output logic [1:0] phase
);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == CNT_W'(CLK_DIV - 1));

    // Counter and phase restart from zero whenever the master goes idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (!enable) begin
            cnt   <= '0;
            phase <= 2'd0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// I2C single-byte write master: START, address+W, ACK, data byte, ACK, STOP,
// driving scl/sda open-drain style (1 = released, 0 = pulled low).
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_write_master_if.master    bus
);

    state_t     state, state_next;
    logic       tick;
    logic [1:0] phase;
    logic       slot_end;
    logic [7:0] shreg;
    logic [7:0] data_q;
    logic [2:0] bit_cnt;
    logic       ack_err_q;
    logic       busy_int;

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (busy_int),
        .tick   (tick),
        .phase  (phase)
    );

    assign slot_end = tick && (phase == Q3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = START;
            START:   if (slot_end) state_next = ADDR;
            ADDR:    if (slot_end && bit_cnt == 3'd7) state_next = ACK1;
            ACK1:    if (slot_end) state_next = bus.sda_in ? STOP : DATA;
            DATA:    if (slot_end && bit_cnt == 3'd7) state_next = ACK2;
            ACK2:    if (slot_end) state_next = STOP;
            STOP:    if (slot_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The shift register carries the address byte first and is reloaded
    // with the data byte when the address is acknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= 8'hFF;
            data_q    <= 8'h00;
            bit_cnt   <= 3'd0;
            ack_err_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            shreg     <= {bus.addr, W_BIT};
            data_q    <= bus.data;
            bit_cnt   <= 3'd0;
            ack_err_q <= 1'b0;
        end else if (slot_end) begin
            case (state)
                ADDR, DATA: begin
                    shreg   <= {shreg[6:0], 1'b1};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ACK1: begin
                    if (bus.sda_in) ack_err_q <= 1'b1;
                    else            shreg     <= data_q;
                end
                ACK2: begin
                    if (bus.sda_in) ack_err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.scl_o = 1'b1;
        bus.sda_o = 1'b1;
        busy_int  = 1'b1;
        bus.done  = 1'b0;
        unique case (state)
            IDLE: busy_int = 1'b0;
            START: begin
                bus.scl_o = (phase != Q3);
                bus.sda_o = (phase == Q0);
            end
            ADDR, DATA: begin
                bus.scl_o = phase[1];
                bus.sda_o = shreg[7];
            end
            ACK1, ACK2: bus.scl_o = phase[1];
            STOP: begin
                bus.scl_o = (phase != Q0);
                bus.sda_o = phase[1];
            end
            DONE: begin
                busy_int = 1'b0;
                bus.done = 1'b1;
            end
            default: busy_int = 1'b0;
        endcase
    end

    assign bus.busy    = busy_int;
    assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: quarter-level line model, bus monitor with an
// acknowledging slave, and directed write transactions.
module tb_i2c_write_master;

    localparam int CLK_DIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    i2c_write_master_if bus();

    logic pull = 1'b0;
    assign bus.sda_in = bus.sda_o & ~pull;

    i2c_write_master #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit slave_nack1 = 1'b0;
    bit slave_nack2 = 1'b0;

    bit         m_active  = 1'b0;
    int         m_n       = 0;
    int         m_lat     = 0;
    logic [6:0] m_addr    = '0;
    logic [7:0] m_data    = '0;
    bit         m_nack1   = 1'b0;
    bit         m_nack2   = 1'b0;
    logic       m_ack_err = 1'b0;

    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         fcount   = 0;
    int         starts   = 0;
    int         stops    = 0;
    int         done_cnt = 0;
    logic       bits[$];
    logic [1:0] w;
    logic       exp_busy, exp_done;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {scl,sda} drive for quarter q of a transaction.
    function automatic logic [1:0] line_at(input int q, input logic [7:0] ab,
                                           input logic [7:0] db, input bit nack1);
        int s, ph, stop_slot;
        logic scl, sda;
        if (q < 4) begin
            case (q)
                0:       return 2'b11;
                1, 2:    return 2'b10;
                default: return 2'b00;
            endcase
        end
        s = (q - 4) / 4;
        ph = (q - 4) % 4;
        stop_slot = nack1 ? 9 : 18;
        if (s == stop_slot) begin
            case (ph)
                0:       return 2'b00;
                1:       return 2'b10;
                default: return 2'b11;
            endcase
        end
        scl = (ph >= 2);
        if (s < 8)       sda = ab[7 - s];
        else if (s == 8) sda = 1'b1;
        else if (s < 17) sda = db[7 - (s - 9)];
        else             sda = 1'b1;
        return {scl, sda};
    endfunction

    // Transaction-timeline model: cycles since accept decide every output.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active  = 1'b0;
            m_ack_err = 1'b0;
        end else if (m_active) begin
            m_n++;
            if (m_n == 160 && m_nack1) m_ack_err = 1'b1;
            if (m_n == 304 && !m_nack1 && m_nack2) m_ack_err = 1'b1;
            if (m_n > m_lat) m_active = 1'b0;
        end else if (bus.start) begin
            m_active  = 1'b1;
            m_n       = 0;
            m_addr    = bus.addr;
            m_data    = bus.data;
            m_nack1   = slave_nack1;
            m_nack2   = slave_nack2;
            m_lat     = slave_nack1 ? 176 : 320;
            m_ack_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (m_active && m_n < m_lat) begin
                w = line_at(m_n / CLK_DIV, {m_addr, 1'b0}, m_data, m_nack1);
                exp_busy = 1'b1;
                exp_done = 1'b0;
            end else begin
                w = 2'b11;
                exp_busy = 1'b0;
                exp_done = m_active;
            end
            checkOutput("scl_o", 32'(bus.scl_o), 32'(w[1]));
            checkOutput("sda_o", 32'(bus.sda_o), 32'(w[0]));
            checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
            checkOutput("done", 32'(bus.done), 32'(exp_done));
            checkOutput("ack_err", 32'(bus.ack_err), 32'(m_ack_err));
        end
    end

    // Bus monitor and slave: decodes START/STOP and bits, pulls SDA in ACK slots.
    always @(negedge clk) begin
        if (!reset) begin
            pull   = 1'b0;
            fcount = 0;
        end else begin
            if (prev_scl && bus.scl_o && prev_sda && !bus.sda_in) begin
                starts++;
                bits.delete();
                fcount = 0;
            end
            if (prev_scl && bus.scl_o && !prev_sda && bus.sda_in) stops++;
            if (!prev_scl && bus.scl_o) bits.push_back(bus.sda_in);
            if (prev_scl && !bus.scl_o) fcount++;
            if (bus.done) done_cnt++;
            pull = (fcount == 9 && !slave_nack1) || (fcount == 18 && !slave_nack2);
        end
        prev_scl = bus.scl_o;
        prev_sda = bus.sda_in;
    end

    task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d,
                                 input bit n1, input bit n2);
        @(negedge clk);
        slave_nack1 = n1;
        slave_nack2 = n2;
        bus.addr  = a;
        bus.data  = d;
        bus.start = 1'b1;
        starts   = 0;
        stops    = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int exp_lat, input bit poke);
        int cycles;
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (poke && cycles == 100) begin
                bus.addr  = 7'h11;
                bus.data  = 8'h22;
                bus.start = 1'b1;
            end else if (poke && cycles == 101) begin
                bus.start = 1'b0;
            end
        end
        checkOutput("latency", 32'(cycles), 32'(exp_lat));
        repeat (5) @(negedge clk);
        checkOutput("done_count", 32'(done_cnt), 32'd1);
        checkOutput("start_cond", 32'(starts), 32'd1);
        checkOutput("stop_cond", 32'(stops), 32'd1);
    endtask

    task automatic checkBits(input int exp_n, input logic [7:0] exp_ab, input logic exp_a1,
                             input logic [7:0] exp_db, input logic exp_a2);
        logic [7:0] b;
        checkOutput("bit_count", 32'(bits.size()), 32'(exp_n));
        if (bits.size() >= 9) begin
            for (int i = 0; i < 8; i++) b[7 - i] = bits[i];
            checkOutput("addr_byte", 32'(b), 32'(exp_ab));
            checkOutput("ack1_bit", 32'(bits[8]), 32'(exp_a1));
        end
        if (exp_n >= 18 && bits.size() >= 18) begin
            for (int i = 0; i < 8; i++) b[7 - i] = bits[9 + i];
            checkOutput("data_byte", 32'(b), 32'(exp_db));
            checkOutput("ack2_bit", 32'(bits[17]), 32'(exp_a2));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.addr  = '0;
        bus.data  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_scl", 32'(bus.scl_o), 32'd1);
        checkOutput("rst_sda", 32'(bus.sda_o), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_ack_err", 32'(bus.ack_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] normal write 0x50 <- 0xA5");
        applyStimulus(7'h50, 8'hA5, 1'b0, 1'b0);
        waitDone(320, 1'b0);
        checkBits(19, 8'hA0, 1'b0, 8'hA5, 1'b0);
        checkOutput("ack_err_normal", 32'(bus.ack_err), 32'd0);

        $display("[TB] address NACK 0x3C");
        applyStimulus(7'h3C, 8'h81, 1'b1, 1'b0);
        waitDone(176, 1'b0);
        checkBits(10, 8'h78, 1'b1, 8'h00, 1'b0);
        checkOutput("ack_err_addr", 32'(bus.ack_err), 32'd1);

        $display("[TB] data NACK 0x2A <- 0x3C");
        applyStimulus(7'h2A, 8'h3C, 1'b0, 1'b1);
        waitDone(320, 1'b0);
        checkBits(19, 8'h54, 1'b0, 8'h3C, 1'b1);
        checkOutput("ack_err_data", 32'(bus.ack_err), 32'd1);

        $display("[TB] clear on start, start while busy ignored");
        applyStimulus(7'h61, 8'h0F, 1'b0, 1'b0);
        checkOutput("ack_err_cleared", 32'(bus.ack_err), 32'd0);
        waitDone(320, 1'b1);
        checkBits(19, 8'hC2, 1'b0, 8'h0F, 1'b0);

        $display("[TB] reset during data phase");
        applyStimulus(7'h50, 8'hA5, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        checkOutput("mid_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_rst_scl", 32'(bus.scl_o), 32'd1);
        checkOutput("mid_rst_sda", 32'(bus.sda_o), 32'd1);
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_rst_ack_err", 32'(bus.ack_err), 32'd0);
        checkOutput("mid_rst_done", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (400) @(negedge clk);
        checkOutput("no_done_after_rst", 32'(done_cnt), 32'd0);

        $display("[TB] recovery write 0x7F <- 0xFF");
        applyStimulus(7'h7F, 8'hFF, 1'b0, 1'b0);
        waitDone(320, 1'b0);
        checkBits(19, 8'hFE, 1'b0, 8'hFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Generates an I2C single-byte write on scl/sda: START, 7-bit address + W bit, ACK slot, one data byte, ACK slot, STOP.
- It is the driving end of the bus whose START/sequence conditions our scl/sda monitor FSM recognises.
- Used as the stimulus source for that monitor in bench and on-chip loopback.
- Open-drain style: the block only ever releases a line or pulls it low.

Parameters:
- CLK_DIV, 4, clk cycles per quarter SCL bit period (≥2).
- CNT_W, 8, width of the quarter-period divider counter (must hold CLK_DIV-1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- addr  input  7  target address, latched on accepted start
- data  input  8  write byte, latched on accepted start
- sda_in  input  1  resolved SDA line value, used for ACK sampling
- scl_o  output  1  SCL drive: 1 = released, 0 = pulled low
- sda_o  output  1  SDA drive: 1 = released, 0 = pulled low
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at end of transaction
- ack_err  output  1  set on any NACK; held until the next accepted start

Behaviour:
- Reset (reset=0, async): scl_o=1, sda_o=1, busy=0, done=0, ack_err=0, FSM=IDLE, divider=0.
- Reset mid-transaction releases both lines immediately. No STOP is generated.
- Quarter tick: the divider counts 0..CLK_DIV-1 while busy; tick when it equals CLK_DIV-1. All FSM/line updates happen only on ticks, except the start accept and done.
- Start accept: start=1 in IDLE latches {addr,0} into an 8-bit shift register, latches data, clears ack_err, and sets busy. Holding the divider at 0 is not required.
- start while busy is ignored.
- States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE.
- START (4 quarters): q0 scl=1,sda=1; q1 sda=0; q2 sda=0; q3 scl=0.
- Bit slot (ADDR/DATA bits, MSB first; ACK slots), 4 quarters each:
  - q0 scl=0, sda=bit (ACK slot: sda=1, released);
  - q1 scl=0;
  - q2 scl=1;
  - q3 scl=1, sample sda_in at q3 in ACK slots;
  - then scl=0 at the next q0.
- ADDR: 8 bit slots, then ACK1.
- ACK1: sampled sda_in=1 -> ack_err=1, go to STOP, skip DATA. Otherwise go to DATA.
- DATA: 8 slots, then ACK2. ACK2: sda_in=1 -> ack_err=1. Always go to STOP.
- STOP (4 quarters): q0 scl=0,sda=0; q1 scl=1,sda=0; q2 scl=1,sda=1; q3 hold.
- DONE: one clk. done=1, busy=0. Next state IDLE.
- Full transaction latency: 80 quarters = 80*CLK_DIV clk from accept to the DONE cycle. NACK-at-address: 44 quarters.
- sda only changes while scl=0, except the START/STOP edges.
- No clock stretching support. scl_o is never read back.

Decomposition:
- Shared package i2c_pkg holds the state encoding constants (IDLE..DONE), the quarter-phase constants Q0..Q3, and the W bit value (0).
- One natural sub-module: i2c_quarter_tick (divider producing the tick and the 2-bit phase).

Test Plan:
- Reset: assert reset=0 mid-DATA -> scl_o=1, sda_o=1, busy=0, ack_err=0 within the same cycle. No done pulse.
- Normal write, CLK_DIV=4, addr=7'h50, data=8'hA5, slave ACKs (sda_in=0 in ACK slots):
  - line shows START;
  - bits 1010_0000 then 1010_0101;
  - STOP;
  - done pulses exactly 320 clk after accept;
  - ack_err=0.
- Address NACK: addr=7'h3C, sda_in=1 in ACK1 -> no data bits on the line, STOP follows, done at 176 clk, ack_err=1.
- Data NACK: ACK1=0, ACK2=1 -> full 320-clk transaction, ack_err=1. The next accepted start clears it.
- start pulsed while busy -> ignored. Latched addr/data unchanged; a single done.
- Protocol check: assert sda_o never toggles while scl_o=1, except the START fall and STOP rise. Run against the scl/sda monitor FSM, which must reach its post-START states.
